// File: rtl/rx_fifo_read_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rx_fifo_read_ctrl_pkg
//   Shared types and constants for the UART receive-FIFO read sequencer.
//   - rd_state_t : read FSM state encoding (also exported as a debug output)
//   - RD_CNT_W   : default width of the delivered-byte counter
//   - WCNT_W     : width of the pop-latency wait counter (POP_LAT is 1..3)
//   - wait_load  : value loaded into the wait counter when a pop is issued
// -----------------------------------------------------------------------------
package rx_fifo_read_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } rd_state_t;

  localparam int RD_CNT_W = 16;
  localparam int WCNT_W   = 2;

  // The FSM spends POP_LAT cycles in WAIT, counting down to zero.
  function automatic logic [WCNT_W-1:0] wait_load(input int pop_lat);
    return WCNT_W'(pop_lat - 1);
  endfunction

endpackage

// File: rtl/rx_fifo_read_ctrl_if.sv
// -----------------------------------------------------------------------------
// rx_fifo_read_ctrl_if
//   Groups the FIFO read port and the host byte stream.
//   FIFO side : Data_Rdy (receiver write strobe, monitored), FIFO_Empty,
//               FIFO_Full (half-full), FIFO_Overflow, FIFO_Data, Pop_Data.
//   Host side : m_data, m_valid, m_ready.
//   Handshake : a byte transfers on every rising clock edge where
//               m_valid & m_ready are both 1. Once m_valid rises, m_data is
//               held stable and m_valid stays high until that transfer.
//   Modports  : master = the read controller, slave = the FIFO/host side.
// -----------------------------------------------------------------------------
interface rx_fifo_read_ctrl_if #(
  parameter int DATA_BITS = 8
);

  logic                 Data_Rdy;
  logic                 FIFO_Empty;
  logic                 FIFO_Full;
  logic                 FIFO_Overflow;
  logic [DATA_BITS-1:0] FIFO_Data;
  logic                 Pop_Data;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    input  Data_Rdy,
    input  FIFO_Empty,
    input  FIFO_Full,
    input  FIFO_Overflow,
    input  FIFO_Data,
    input  m_ready,
    output Pop_Data,
    output m_data,
    output m_valid
  );

  modport slave (
    output Data_Rdy,
    output FIFO_Empty,
    output FIFO_Full,
    output FIFO_Overflow,
    output FIFO_Data,
    output m_ready,
    input  Pop_Data,
    input  m_data,
    input  m_valid
  );

endinterface

// File: rtl/rx_fifo_read_ctrl_status.sv
// -----------------------------------------------------------------------------
// rx_status_regs
//   Status registers beside the read sequencer.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     i_overflow      FIFO overflow flag (any high cycle sets the sticky bit)
//     i_full          FIFO half-full flag
//     i_clr           clears the sticky bit and the byte counter
//     i_hs            host handshake (m_valid & m_ready) this cycle
//     o_ovf_sticky    overflow seen since the last clear
//     o_half_irq      i_full delayed by one cycle
//     o_rd_count      bytes delivered, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module rx_status_regs #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_overflow,
  input  logic             i_full,
  input  logic             i_clr,
  input  logic             i_hs,
  output logic             o_ovf_sticky,
  output logic             o_half_irq,
  output logic [CNT_W-1:0] o_rd_count
);

  logic             r_ovf_sticky;
  logic             r_half_irq;
  logic [CNT_W-1:0] r_rd_count;

  // Set has priority over clear so an overflow in the clearing cycle is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
    end else if (i_overflow) begin
      r_ovf_sticky <= 1'b1;
    end else if (i_clr) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half_irq <= 1'b0;
    end else begin
      r_half_irq <= i_full;
    end
  end

  // A clear coinciding with a delivery counts that delivery, giving 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count <= '0;
    end else if (i_clr) begin
      r_rd_count <= i_hs ? CNT_W'(1) : '0;
    end else if (i_hs) begin
      r_rd_count <= r_rd_count + CNT_W'(1);
    end
  end

  assign o_ovf_sticky = r_ovf_sticky;
  assign o_half_irq   = r_half_irq;
  assign o_rd_count   = r_rd_count;

endmodule

// File: rtl/rx_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// rx_fifo_read_ctrl
//   Read-side sequencer for the UART receive FIFO. Issues one-cycle Pop_Data
//   strobes, captures FIFO_Data POP_LAT cycles later into a registered output
//   slot and offers it to the host on a valid/ready stream.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     enable        allow new pops
//     BIST_Mode     FIFO under self-test; blocks new pops like enable=0
//     clr_status    clears ovf_sticky and rd_count
//     bus           FIFO read port + host stream (master modport)
//     ovf_sticky    overflow seen since last clear
//     half_irq      registered copy of FIFO_Full
//     rd_count      bytes delivered, modulo 2^CNT_W
//     o_dbg_state   current read FSM state
// -----------------------------------------------------------------------------
module rx_fifo_read_ctrl
  import rx_fifo_read_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int POP_LAT   = 1,
  parameter int CNT_W     = RD_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              BIST_Mode,
  input  logic              clr_status,
  rx_fifo_read_ctrl_if.master bus,
  output logic              ovf_sticky,
  output logic              half_irq,
  output logic [CNT_W-1:0]  rd_count,
  output rd_state_t         o_dbg_state
);

  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic [WCNT_W-1:0]     r_wcnt;
  logic [WCNT_W-1:0]     w_wcnt_nxt;
  logic [DATA_BITS-1:0]  r_m_data;
  logic                  r_m_valid;

  logic                  w_go;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_capture;
  logic                  w_release;

  assign w_go = enable & ~BIST_Mode & ~bus.FIFO_Empty;
  assign w_hs = r_m_valid & bus.m_ready;

  // Next-state and strobes. Data_Rdy gates the pop combinationally because
  // the FIFO gives receiver writes priority; POP simply retries next cycle,
  // and it is never abandoned once entered, whatever enable does.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_go) begin
          w_state_nxt = POP;
        end
      end
      POP: begin
        if (!bus.Data_Rdy) begin
          w_pop       = 1'b1;
          w_wcnt_nxt  = wait_load(POP_LAT);
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_wcnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_wcnt_nxt = r_wcnt - WCNT_W'(1);
        end
      end
      HOLD: begin
        // FIFO_Empty is looked at again here, so an emptied FIFO is not popped.
        if (w_hs) begin
          w_release   = 1'b1;
          w_state_nxt = w_go ? POP : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Output slot: loaded once per byte, held until the host takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_m_data  <= bus.FIFO_Data;
        r_m_valid <= 1'b1;
      end else if (w_release) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign bus.Pop_Data = w_pop;
  assign bus.m_data   = r_m_data;
  assign bus.m_valid  = r_m_valid;
  assign o_dbg_state  = r_state;

  rx_status_regs #(
    .CNT_W (CNT_W)
  ) u_status (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_overflow   (bus.FIFO_Overflow),
    .i_full       (bus.FIFO_Full),
    .i_clr        (clr_status),
    .i_hs         (w_hs),
    .o_ovf_sticky (ovf_sticky),
    .o_half_irq   (half_irq),
    .o_rd_count   (rd_count)
  );

  // A pop while a byte is still held would overwrite the slot.
  a_no_pop_while_valid : assert property (
    @(posedge clk) disable iff (!rst_n) w_pop |-> !r_m_valid
  );

  a_hold_means_valid : assert property (
    @(posedge clk) disable iff (!rst_n) (r_state == HOLD) |-> r_m_valid
  );

endmodule

// File: tb/tb_rx_fifo_read_ctrl.sv
module tb_rx_fifo_read_ctrl;
  import rx_fifo_read_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int PL = 1;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic BIST_Mode;
  logic clr_status;
  logic ovf_sticky;
  logic half_irq;
  logic [CW-1:0] rd_count;
  rd_state_t dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rx_fifo_read_ctrl_if #(.DATA_BITS(DW)) ifc ();

  rx_fifo_read_ctrl #(
    .DATA_BITS (DW),
    .POP_LAT   (PL),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .BIST_Mode   (BIST_Mode),
    .clr_status  (clr_status),
    .bus         (ifc),
    .ovf_sticky  (ovf_sticky),
    .half_irq    (half_irq),
    .rd_count    (rd_count),
    .o_dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- FIFO model + scoreboard ----------------
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            pop_cyc_q[$];
  int            n_pops = 0;
  int            n_hs   = 0;
  int            pend_cnt = 0;
  logic [DW-1:0] pend_data;
  int            last_pop_cyc = 0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DW-1:0] prev_data;
  logic [CW-1:0] model_cnt = '0;
  logic          model_ovf = 1'b0;
  logic          model_half = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      // FIFO read port: popped byte shows on FIFO_Data POP_LAT cycles later,
      // other cycles carry junk so a mistimed capture is visible.
      if (pend_cnt > 0) begin
        pend_cnt--;
        ifc.FIFO_Data = (pend_cnt == 0) ? pend_data : DW'($urandom);
      end else begin
        ifc.FIFO_Data = DW'($urandom);
      end
      if (!rst_n) begin
        exp_q.delete();
        pend_cnt   = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        model_cnt  = '0;
        model_ovf  = 1'b0;
        model_half = 1'b0;
      end else begin
        n_tests++;
        if (rd_count !== model_cnt) begin
          n_fail++;
          $display("FAIL rd_count_track @%0d: got %0d want %0d", cyc, rd_count, model_cnt);
        end
        n_tests++;
        if (ovf_sticky !== model_ovf) begin
          n_fail++;
          $display("FAIL ovf_track @%0d: got %b want %b", cyc, ovf_sticky, model_ovf);
        end
        n_tests++;
        if (half_irq !== model_half) begin
          n_fail++;
          $display("FAIL half_irq_track @%0d: got %b want %b", cyc, half_irq, model_half);
        end
        if (ifc.Pop_Data === 1'b1) begin
          n_tests++;
          if (ifc.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_while_valid @%0d: m_valid=%b want 0", cyc, ifc.m_valid);
          end
          n_tests++;
          if (fifo_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_on_empty @%0d: pop with fifo size 0", cyc);
          end else begin
            pend_data = fifo_q.pop_front();
            pend_cnt  = PL;
            exp_q.push_back(pend_data);
          end
          n_pops++;
          pop_cyc_q.push_back(cyc);
          last_pop_cyc = cyc;
        end
        if (ifc.m_valid === 1'b1 && !prev_valid) begin
          n_tests++;
          if (cyc - last_pop_cyc != PL + 1) begin
            n_fail++;
            $display("FAIL latency @%0d: got %0d want %0d", cyc, cyc - last_pop_cyc, PL + 1);
          end
        end
        if (ifc.m_valid === 1'b1 && prev_valid && !prev_ready) begin
          n_tests++;
          if (ifc.m_data !== prev_data) begin
            n_fail++;
            $display("FAIL hold_stable @%0d: got %h want %h", cyc, ifc.m_data, prev_data);
          end
        end
        if (ifc.m_valid === 1'b1 && ifc.m_ready === 1'b1) begin
          n_hs++;
          got_q.push_back(ifc.m_data);
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL data_order @%0d: got %h want nothing", cyc, ifc.m_data);
          end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (ifc.m_data !== e) begin
              n_fail++;
              $display("FAIL data_order @%0d: got %h want %h", cyc, ifc.m_data, e);
            end
          end
        end
        // next-cycle expectations for the status registers
        if (clr_status) model_cnt = (ifc.m_valid && ifc.m_ready) ? CW'(1) : '0;
        else if (ifc.m_valid && ifc.m_ready) model_cnt = model_cnt + CW'(1);
        if (ifc.FIFO_Overflow) model_ovf = 1'b1;
        else if (clr_status) model_ovf = 1'b0;
        model_half = ifc.FIFO_Full;
        prev_valid = (ifc.m_valid === 1'b1);
        prev_ready = (ifc.m_ready === 1'b1);
        prev_data  = ifc.m_data;
      end
      ifc.FIFO_Empty = (fifo_q.size() == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input rd_state_t s, input string nm);
    int k = 0;
    while (dbg_state !== s && k < 50) begin
      tick();
      k++;
    end
    n_tests++;
    if (dbg_state !== s) begin
      n_fail++;
      $display("FAIL %s timeout: state=%0d want %0d", nm, dbg_state, s);
    end
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (ifc.m_valid !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    n_tests++;
    if (ifc.m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: m_valid=%b want 1", nm, ifc.m_valid);
    end
  endtask

  task automatic check_all_zero(input string nm);
    n_tests++;
    if (ifc.Pop_Data !== 1'b0 || ifc.m_valid !== 1'b0 || ifc.m_data !== '0 ||
        ovf_sticky !== 1'b0 || half_irq !== 1'b0 || rd_count !== '0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL %s: pop=%b vld=%b data=%h ovf=%b half=%b cnt=%0d st=%0d want all 0/IDLE",
               nm, ifc.Pop_Data, ifc.m_valid, ifc.m_data, ovf_sticky, half_irq, rd_count, dbg_state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int r0;
    logic exp_pop;
    rst_n = 1'b0;
    enable = 1'b1;
    fifo_q.delete();
    fifo_q.push_back(8'hA5);
    ifc.FIFO_Empty = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_values");
    tick();
    rst_n = 1'b1;
    r0 = cyc;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_pop = (cyc - r0 == 1);
      n_tests++;
      if (ifc.Pop_Data !== exp_pop) begin
        n_fail++;
        $display("FAIL first_pop cycle %0d: got %b want %b", cyc - r0, ifc.Pop_Data, exp_pop);
      end
    end
    n_tests++;
    if (ifc.m_valid !== 1'b1 || ifc.m_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL first_byte: vld=%b data=%h want 1/a5", ifc.m_valid, ifc.m_data);
    end
    tick();
    ifc.m_ready = 1'b1;
    tick();
    ifc.m_ready = 1'b0;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_data_rdy_retry();
    int p0, h0;
    p0 = n_pops;
    h0 = n_hs;
    ifc.m_ready = 1'b1;
    ifc.Data_Rdy = 1'b1;
    fifo_q.push_back(DW'($urandom));
    enable = 1'b1;
    wait_state(POP, "retry_enter_pop");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (ifc.Pop_Data !== 1'b0) begin
        n_fail++;
        $display("FAIL retry_blocked %0d: got %b want 0", k, ifc.Pop_Data);
      end
      tick();
    end
    ifc.Data_Rdy = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ifc.Pop_Data !== 1'b1) begin
      n_fail++;
      $display("FAIL retry_pop: got %b want 1", ifc.Pop_Data);
    end
    repeat (6) tick();
    n_tests++;
    if (n_pops - p0 != 1 || n_hs - h0 != 1) begin
      n_fail++;
      $display("FAIL retry_counts: pops=%0d bytes=%0d want 1/1", n_pops - p0, n_hs - h0);
    end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] b1, b2;
    int p0;
    b1 = DW'($urandom);
    b2 = DW'($urandom);
    ifc.m_ready = 1'b0;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    fifo_q.push_back(b1);
    fifo_q.push_back(b2);
    enable = 1'b1;
    wait_valid("bp_first_valid");
    n_tests++;
    if (ifc.m_data !== b1 || rd_count !== '0) begin
      n_fail++;
      $display("FAIL bp_first: data=%h cnt=%0d want %h/0", ifc.m_data, rd_count, b1);
    end
    p0 = n_pops;
    repeat (5) begin
      tick();
      n_tests++;
      if (ifc.m_valid !== 1'b1 || ifc.m_data !== b1) begin
        n_fail++;
        $display("FAIL bp_hold: vld=%b data=%h want 1/%h", ifc.m_valid, ifc.m_data, b1);
      end
    end
    n_tests++;
    if (n_pops != p0) begin
      n_fail++;
      $display("FAIL bp_no_pop: got %0d pops want 0", n_pops - p0);
    end
    ifc.m_ready = 1'b1;
    tick();
    n_tests++;
    if (rd_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 1", rd_count);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.Pop_Data !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_next_pop: got %b want 1", ifc.Pop_Data);
    end
    repeat (6) tick();
    ifc.m_ready = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_stream();
    int p0, h0, k;
    ifc.m_ready = 1'b1;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    got_q.delete();
    pop_cyc_q.delete();
    p0 = n_pops;
    h0 = n_hs;
    for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(i));
    enable = 1'b1;
    k = 0;
    while (n_hs - h0 < 16 && k < 200) begin
      tick();
      k++;
    end
    n_tests++;
    if (rd_count !== CW'(16) || got_q.size() != 16) begin
      n_fail++;
      $display("FAIL stream_count: cnt=%0d got=%0d want 16/16", rd_count, got_q.size());
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== DW'(i)) begin
        n_fail++;
        $display("FAIL stream_data[%0d]: got %h want %h", i, got_q[i], DW'(i));
      end
    end
    for (int i = 1; i < pop_cyc_q.size(); i++) begin
      n_tests++;
      if (pop_cyc_q[i] - pop_cyc_q[i-1] != PL + 2) begin
        n_fail++;
        $display("FAIL stream_spacing[%0d]: got %0d want %0d", i, pop_cyc_q[i] - pop_cyc_q[i-1], PL + 2);
      end
    end
    repeat (10) tick();
    n_tests++;
    if (n_pops - p0 != 16) begin
      n_fail++;
      $display("FAIL stream_pops: got %0d want 16", n_pops - p0);
    end
    enable = 1'b0;
    ifc.m_ready = 1'b0;
  endtask

  task automatic test_status();
    ifc.FIFO_Overflow = 1'b1;
    tick();
    ifc.FIFO_Overflow = 1'b0;
    n_tests++;
    if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf_sticky); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    n_tests++;
    if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", ovf_sticky); end
    clr_status = 1'b1;
    ifc.FIFO_Overflow = 1'b1;
    tick();
    clr_status = 1'b0;
    ifc.FIFO_Overflow = 1'b0;
    n_tests++;
    if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", ovf_sticky); end
    ifc.FIFO_Full = 1'b1;
    tick();
    n_tests++;
    if (half_irq !== 1'b1) begin n_fail++; $display("FAIL half_irq_rise: got %b want 1", half_irq); end
    ifc.FIFO_Full = 1'b0;
    tick();
    n_tests++;
    if (half_irq !== 1'b0) begin n_fail++; $display("FAIL half_irq_fall: got %b want 0", half_irq); end
    // clear together with a delivery leaves the counter at 1
    fifo_q.push_back(DW'($urandom));
    enable = 1'b1;
    wait_valid("clr_hs_valid");
    clr_status = 1'b1;
    ifc.m_ready = 1'b1;
    tick();
    clr_status = 1'b0;
    ifc.m_ready = 1'b0;
    enable = 1'b0;
    n_tests++;
    if (rd_count !== CW'(1)) begin n_fail++; $display("FAIL clr_with_hs: got %0d want 1", rd_count); end
    tick();
  endtask

  task automatic test_bist();
    int p0, h0;
    p0 = n_pops;
    h0 = n_hs;
    BIST_Mode = 1'b1;
    enable = 1'b1;
    ifc.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) fifo_q.push_back(DW'($urandom));
    repeat (10) tick();
    n_tests++;
    if (n_pops != p0) begin n_fail++; $display("FAIL bist_blocks: got %0d pops want 0", n_pops - p0); end
    BIST_Mode = 1'b0;
    repeat (15) tick();
    n_tests++;
    if (n_pops - p0 != 3 || n_hs - h0 != 3) begin
      n_fail++;
      $display("FAIL bist_resume: pops=%0d bytes=%0d want 3/3", n_pops - p0, n_hs - h0);
    end
    enable = 1'b0;
    ifc.m_ready = 1'b0;
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 400; i++) begin
      enable            = ($urandom_range(0, 9) < 8);
      BIST_Mode         = ($urandom_range(0, 9) == 0);
      ifc.Data_Rdy      = ($urandom_range(0, 3) == 0);
      ifc.m_ready       = ($urandom_range(0, 1) == 1);
      ifc.FIFO_Overflow = ($urandom_range(0, 19) == 0);
      ifc.FIFO_Full     = ($urandom_range(0, 1) == 1);
      clr_status        = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) < 3 && fifo_q.size() < 16) fifo_q.push_back(DW'($urandom));
      tick();
    end
    enable = 1'b1;
    BIST_Mode = 1'b0;
    ifc.Data_Rdy = 1'b0;
    ifc.m_ready = 1'b1;
    ifc.FIFO_Overflow = 1'b0;
    clr_status = 1'b0;
    k = 0;
    while ((fifo_q.size() != 0 || ifc.m_valid === 1'b1 || dbg_state !== IDLE) && k < 300) begin
      tick();
      k++;
    end
    repeat (3) tick();
    n_tests++;
    if (exp_q.size() != 0 || fifo_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: undelivered=%0d queued=%0d want 0/0", exp_q.size(), fifo_q.size());
    end
    enable = 1'b0;
    ifc.m_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    ifc.FIFO_Overflow = 1'b1;
    ifc.FIFO_Full = 1'b1;
    tick();
    ifc.FIFO_Overflow = 1'b0;
    ifc.m_ready = 1'b0;
    fifo_q.push_back(DW'($urandom));
    enable = 1'b1;
    wait_state(WAIT, "rst_enter_wait");
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_wait");
    fifo_q.delete();
    ifc.FIFO_Empty = 1'b1;
    ifc.FIFO_Full = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if (ifc.Pop_Data !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_no_pop cycle %0d: got %b want 0", i, ifc.Pop_Data);
      end
    end
    enable = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence / report ----------------
  initial begin
    rst_n             = 1'b0;
    enable            = 1'b0;
    BIST_Mode         = 1'b0;
    clr_status        = 1'b0;
    ifc.Data_Rdy      = 1'b0;
    ifc.FIFO_Empty    = 1'b1;
    ifc.FIFO_Full     = 1'b0;
    ifc.FIFO_Overflow = 1'b0;
    ifc.FIFO_Data     = '0;
    ifc.m_ready       = 1'b0;
    test_reset();
    test_data_rdy_retry();
    test_backpressure();
    test_stream();
    test_status();
    test_bist();
    test_random();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
